// File: rtl/buffer_sched_pkg.sv
// Shared sizing and SRAM encoding constants for the 16-entry bit buffer scheduler.
package buffer_sched_pkg;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    localparam logic SRAM_WRITE = 1'b1;
    localparam logic SRAM_READ  = 1'b0;
    localparam logic DEN_ON     = 1'b0;
    localparam logic DEN_OFF    = 1'b1;

    typedef struct packed {
        logic          den;
        logic          rdwr;
        logic [AW-1:0] addr1;
        logic [AW-1:0] addr2;
        logic          wline;
    } sram_cmd_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, priority flips to the loser
// on any grant taken while update is high. Requester 0 is favoured after reset.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic gnt0,
    output logic gnt1
);
    logic prio1;

    always_comb begin
        gnt0 = req0 && (!req1 || !prio1);
        gnt1 = req1 && (!req0 ||  prio1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio1 <= 1'b0;
        end else if (update && (gnt0 || gnt1)) begin
            prio1 <= gnt0;
        end
    end
endmodule

// File: rtl/buffer_sched.sv
// 16-entry bit circular buffer over a 1-op/cycle SRAM; SRAM op one cycle after grant,
// read data valid two cycles after grant. Refused requests get no ack and must be held.
module buffer_sched
    import buffer_sched_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_req,
    input  logic          wr_bit,
    output logic          wr_ack,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic          rd_data0,
    output logic          rd_data1,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] sram_addr1,
    output logic [AW-1:0] sram_addr2,
    output logic          sram_wline,
    output logic          sram_rdwr,
    output logic          sram_den,
    input  logic          sram_rline1,
    input  logic          sram_rline2
);
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          rd_pend;
    sram_cmd_t     cmd;
    logic          wr_elig;
    logic          rd_elig;
    logic          allow;
    logic          gnt_w;
    logic          gnt_r;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign wr_elig = wr_req && !full;
    assign rd_elig = rd_req && (cnt >= CW'(2));
    assign allow   = !reset && !flush;

    // Priority only advances on a grant that is actually issued.
    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0   (wr_elig),
        .req1   (rd_elig),
        .update (allow),
        .gnt0   (gnt_w),
        .gnt1   (gnt_r)
    );

    assign wr_ack = gnt_w && allow;
    assign rd_ack = gnt_r && allow;

    assign sram_den   = cmd.den;
    assign sram_rdwr  = cmd.rdwr;
    assign sram_addr1 = cmd.addr1;
    assign sram_addr2 = cmd.addr2;
    assign sram_wline = cmd.wline;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data0 <= 1'b0;
            rd_data1 <= 1'b0;
            cmd      <= '{den: DEN_OFF, rdwr: SRAM_READ, addr1: '0, addr2: '0, wline: 1'b0};
        end else begin
            // An in-flight read completes even across a flush.
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data0 <= sram_rline1;
                rd_data1 <= sram_rline2;
            end
            rd_pend  <= rd_ack;
            cmd.den  <= DEN_OFF;
            cmd.rdwr <= SRAM_READ;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else if (wr_ack) begin
                cmd.den   <= DEN_ON;
                cmd.rdwr  <= SRAM_WRITE;
                cmd.addr1 <= wptr;
                cmd.wline <= wr_bit;
                wptr      <= wptr + AW'(1);
                cnt       <= cnt + CW'(1);
            end else if (rd_ack) begin
                cmd.den   <= DEN_ON;
                cmd.rdwr  <= SRAM_READ;
                cmd.addr1 <= rptr;
                cmd.addr2 <= rptr + AW'(1);
                rptr      <= rptr + AW'(2);
                cnt       <= cnt - CW'(2);
            end
        end
    end
endmodule

// File: tb/tb_buffer_sched.sv
// Directed plus random stimulus for buffer_sched, scored against a queue-based model
// of the buffer, a behavioural SRAM array and a last-winner arbitration rule.
module tb_buffer_sched;
    logic       clk;
    logic       reset;
    logic       flush;
    logic       wr_req;
    logic       wr_bit;
    logic       wr_ack;
    logic       rd_req;
    logic       rd_ack;
    logic       rd_valid;
    logic       rd_data0;
    logic       rd_data1;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic [3:0] sram_addr1;
    logic [3:0] sram_addr2;
    logic       sram_wline;
    logic       sram_rdwr;
    logic       sram_den;
    logic       sram_rline1;
    logic       sram_rline2;

    logic mem [0:15];

    int n_cmp = 0;
    int n_err = 0;

    bit   q[$];
    int   wp, rp;
    bit   prio_w;
    bit   infl, pd0, pd1;
    logic e_den, e_rdwr, e_wl, e_rdv, e_d0, e_d1;
    logic [3:0] e_a1, e_a2;

    buffer_sched dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .wr_req      (wr_req),
        .wr_bit      (wr_bit),
        .wr_ack      (wr_ack),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data0    (rd_data0),
        .rd_data1    (rd_data1),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .sram_addr1  (sram_addr1),
        .sram_addr2  (sram_addr2),
        .sram_wline  (sram_wline),
        .sram_rdwr   (sram_rdwr),
        .sram_den    (sram_den),
        .sram_rline1 (sram_rline1),
        .sram_rline2 (sram_rline2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (sram_den == 1'b0 && sram_rdwr == 1'b1) mem[sram_addr1] <= sram_wline;
    end
    assign sram_rline1 = mem[sram_addr1];
    assign sram_rline2 = mem[sram_addr2];

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wp = 0; rp = 0; prio_w = 1'b1; infl = 1'b0; pd0 = 1'b0; pd1 = 1'b0;
        e_den = 1'b1; e_rdwr = 1'b0; e_a1 = '0; e_a2 = '0; e_wl = 1'b0;
        e_rdv = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    endtask

    // One clock cycle: drive, check acks and current outputs, clock, advance the model.
    task automatic cycle(input bit w, input bit wb, input bit r, input bit f, input bit rs);
        bit ew, er, gw, gr;
        wr_req = w; wr_bit = wb; rd_req = r; flush = f; reset = rs;
        #1;
        ew = w && (q.size() < 16);
        er = r && (q.size() >= 2);
        gw = 1'b0; gr = 1'b0;
        if (!rs && !f) begin
            if (ew && er) begin
                gw = prio_w;
                gr = !prio_w;
            end else begin
                gw = ew;
                gr = er;
            end
        end
        chk("wr_ack",   5'(wr_ack),   5'(gw));
        chk("rd_ack",   5'(rd_ack),   5'(gr));
        chk("count",    count,        5'(q.size()));
        chk("full",     5'(full),     5'(q.size() == 16));
        chk("empty",    5'(empty),    5'(q.size() == 0));
        chk("den",      5'(sram_den), 5'(e_den));
        chk("rdwr",     5'(sram_rdwr), 5'(e_rdwr));
        chk("addr1",    5'(sram_addr1), 5'(e_a1));
        chk("addr2",    5'(sram_addr2), 5'(e_a2));
        chk("wline",    5'(sram_wline), 5'(e_wl));
        chk("rd_valid", 5'(rd_valid), 5'(e_rdv));
        chk("rd_data0", 5'(rd_data0), 5'(e_d0));
        chk("rd_data1", 5'(rd_data1), 5'(e_d1));
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
        end else begin
            e_rdv = infl;
            if (infl) begin
                e_d0 = pd0;
                e_d1 = pd1;
            end
            infl = 1'b0;
            e_den = 1'b1;
            e_rdwr = 1'b0;
            if (f) begin
                q.delete();
                wp = 0;
                rp = 0;
            end else if (gw) begin
                q.push_back(wb);
                e_den = 1'b0; e_rdwr = 1'b1; e_a1 = 4'(wp); e_wl = wb;
                wp = (wp + 1) % 16;
                prio_w = 1'b0;
            end else if (gr) begin
                pd0 = q.pop_front();
                pd1 = q.pop_front();
                infl = 1'b1;
                e_den = 1'b0; e_a1 = 4'(rp); e_a2 = 4'((rp + 1) % 16);
                rp = (rp + 2) % 16;
                prio_w = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wr_req = 1'b0; wr_bit = 1'b0; rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, with a write request held to confirm acks stay low.
        cycle(1, 1, 0, 0, 1);

        // Three writes 1,0,1 then a single read of the oldest pair.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Fill to 16, hold a 17th write while full, then let a read make room.
        for (int i = 0; i < 15; i++) cycle(1, i[0], 0, 0, 0);
        repeat (3) cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        repeat (3) cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Contention at count 8: expect W,R,W,R.
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(1, i[1], 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (4) cycle(1, 1, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Read granted, reset the following cycle: the read must vanish.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Flush at count 10 with a read in flight and both requests high.
        for (int i = 0; i < 12; i++) cycle(1, i[0] ^ i[2], 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 1, 1, 0);
        cycle(1, 1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/buffer_sched.md
BUFFER_SCHED -- requirements
Module: buffer_sched

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: `clk` and `reset`.
REQ-002 Port `clk`  in  1  system clock; all state updates on rising edge.
REQ-003 Port `reset`  in  1  synchronous active-high reset.
REQ-004 Port `flush`  in  1  synchronous buffer clear.
REQ-005 Port `wr_req`  in  1  writer requests one bit store.
REQ-006 Port `wr_bit`  in  1  bit to store, valid with `wr_req`.
REQ-007 Port `wr_ack`  out  1  write granted this cycle (combinational).
REQ-008 Port `rd_req`  in  1  reader requests a two-bit read.
REQ-009 Port `rd_ack`  out  1  read granted this cycle (combinational).
REQ-010 Port `rd_valid`  out  1  `rd_data0`/`rd_data1` valid, one-cycle pulse.
REQ-011 Port `rd_data0`, `rd_data1`  out  1 each  older bit and newer bit of the pair.
REQ-012 Port `count`  out  5  occupied entries, 0..16.
REQ-013 Port `full` / `empty`  out  1 each  full is count==16; empty is count==0.
REQ-014 Port `sram_addr1`, `sram_addr2`  out  4 each  SRAM addresses.
REQ-015 Port `sram_wline`  out  1  SRAM write data.
REQ-016 Port `sram_rdwr`  out  1  SRAM direction: 1 = write, 0 = read.
REQ-017 Port `sram_den`  out  1  SRAM enable, active low.
REQ-018 Port `sram_rline1`, `sram_rline2`  in  1 each  SRAM read data for addr1 and addr2.

Function
REQ-019 Scope: the block SHALL own the 16-entry circular buffer and issue at most one SRAM operation per cycle.
REQ-020 Write eligibility: `wr_req` && !`full`.
REQ-021 Read eligibility: `rd_req` && `count` >= 2.
REQ-022 Arbitration, one eligible: the eligible request SHALL be granted.
REQ-023 Arbitration, both eligible: round-robin; the requester not granted last time wins; after reset, write wins first.
REQ-024 Grant cycle N, write: assert `wr_ack`; cycle N+1 drives `sram_rdwr`=1, `sram_den`=0, `sram_addr1`=wptr(N), `sram_wline`=`wr_bit`(N).
REQ-025 Grant cycle N, read: assert `rd_ack`; cycle N+1 drives `sram_rdwr`=0, `sram_den`=0, `sram_addr1`=rptr, `sram_addr2`=rptr+1 mod 16.
REQ-026 Read data: `sram_rline1`/`sram_rline2` SHALL be sampled at the rising edge ending N+1; `rd_valid`=1 during N+2 only; read latency is 2.
REQ-027 `rd_data0`/`rd_data1` SHALL hold their values until the next `rd_valid`.
REQ-028 Idle cycles: `sram_den`=1, `sram_rdwr`=0, addresses and `sram_wline` hold their previous values.
REQ-029 Pointer update at the grant edge: write wptr+=1, count+=1; read rptr+=2, count-=2; all 4-bit pointers wrap mod 16.
REQ-030 Stall: a refused request (full, or count<2) SHALL get no ack and cause no state change; the requester holds its request.
REQ-031 Flush: `flush` SHALL have priority over both requests: no grant that cycle; wptr, rptr and count go to 0; the round-robin pointer is kept.
REQ-032 Flush with a read in flight: `rd_valid` SHALL still pulse with data read from the old contents.

Reset
REQ-033 Reset values: `count`=0, wptr=0, rptr=0, `empty`=1, `full`=0, `rd_valid`=0, `rd_data0`/`rd_data1`=0, `sram_den`=1, `sram_rdwr`=0, `sram_addr1`/`sram_addr2`=0, `sram_wline`=0, round-robin priority=write.
REQ-034 Reset mid-operation: any in-flight read SHALL be dropped (no `rd_valid`); acks SHALL be 0 while `reset` is high.

Structure
REQ-035 Shared package: DEPTH=16, AW=4, CW=5, SRAM_WRITE=1, SRAM_READ=0, DEN_ON=0.
REQ-036 Sub-module: one, `rr_arb2`, a two-requester round-robin arbiter with an update-on-grant input; the rest stays in `buffer_sched`.

Verification
REQ-037 Reset then 3 writes (bits 1,0,1) -> `wr_ack` 3 cycles; addr1 0,1,2 with `sram_rdwr`=1 one cycle later; `count`=3.
REQ-038 After REQ-037, `rd_req` for 1 cycle -> `rd_ack`; next cycle addr1=0, addr2=1, rdwr=0; following cycle `rd_valid`=1, data0=1, data1=0, `count`=1.
REQ-039 16 writes, then a 17th held -> `full`=1; 17th gets no ack until a read is granted; wptr wraps to 0.
REQ-040 Both `wr_req` and `rd_req` held at count=8 -> grants alternate W,R,W,R starting with W; `count` goes 9,7,8,6.
REQ-041 Read granted, then `reset` the next cycle -> no `rd_valid`; all outputs at reset values.
REQ-042 `flush` with `count`=10 and both requests high -> no ack that cycle; `count`=0, `empty`=1; next write goes to addr 0.
